// File: rtl/memory_turn_engine.sv
// rtl/memory_turn_engine.sv - card-matching game engine: turns, per-turn timer, scoring, winner
module memory_turn_engine #(
   parameter int  NUM_CARDS     = 16,
   parameter int  NUM_PLAYERS   = 2,
   parameter int  TICKS_PER_SEC = 50_000_000,
   parameter int  TURN_SEC      = 15,
   parameter int  SHOW_SEC      = 1,
   localparam int IW            = $clog2(NUM_CARDS),
   localparam int VW            = $clog2(NUM_CARDS / 2),
   localparam int SW            = $clog2(NUM_CARDS / 2 + 1),
   localparam int PW            = $clog2(NUM_PLAYERS),
   localparam int WW            = $clog2(NUM_PLAYERS + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      sel_valid,
   input  logic [IW-1:0]             sel_idx,
   input  logic [VW-1:0]             card_val,
   output logic [2:0]                state,
   output logic [PW-1:0]             cur_player,
   output logic [NUM_CARDS-1:0]      face_up,
   output logic [NUM_CARDS-1:0]      matched,
   output logic [NUM_PLAYERS*SW-1:0] scores,
   output logic [4:0]                secs_left,
   output logic                      game_over,
   output logic [WW-1:0]             winner
);
   localparam int              SHOW_CYC    = SHOW_SEC * TICKS_PER_SEC;
   localparam int              TW          = $clog2(TICKS_PER_SEC + 1);
   localparam int              CW          = $clog2(SHOW_CYC + 1);
   localparam int              IW1         = IW + 1;
   localparam logic [TW-1:0]   PRESC_LAST  = TW'(TICKS_PER_SEC - 1);
   localparam logic [CW-1:0]   SHOW_LAST   = CW'(SHOW_CYC - 1);
   localparam logic [4:0]      TURN_RELOAD = 5'(TURN_SEC);
   localparam logic [SW-1:0]   SCORE_MAX   = SW'(NUM_CARDS / 2);
   localparam logic [PW-1:0]   LAST_PLAYER = PW'(NUM_PLAYERS - 1);
   localparam logic [IW1-1:0]  CARD_LIMIT  = IW1'(NUM_CARDS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PICK1 = 3'd1,
      S_PICK2 = 3'd2,
      S_SHOW  = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t                    state_q, state_d;
   logic [PW-1:0]             player_q, player_d;
   logic [NUM_CARDS-1:0]      face_q, face_d;
   logic [NUM_CARDS-1:0]      matched_q, matched_d;
   logic [NUM_PLAYERS*SW-1:0] scores_q, scores_d;
   logic [4:0]                secs_q, secs_d;
   logic                      game_over_q, game_over_d;
   logic [WW-1:0]             winner_q, winner_d;
   logic [TW-1:0]             presc_q, presc_d;
   logic [CW-1:0]             show_q, show_d;
   logic [IW-1:0]             first_idx_q, first_idx_d;
   logic [IW-1:0]             second_idx_q, second_idx_d;
   logic [VW-1:0]             first_val_q, first_val_d;

   logic          pick_ok, running, wrap, timeout, tie;
   logic [PW-1:0] next_player;
   logic [SW-1:0] best;
   logic [WW-1:0] win_idx;

   always_comb begin
      state_d      = state_q;
      player_d     = player_q;
      face_d       = face_q;
      matched_d    = matched_q;
      scores_d     = scores_q;
      secs_d       = secs_q;
      game_over_d  = game_over_q;
      winner_d     = winner_q;
      presc_d      = presc_q;
      show_d       = show_q;
      first_idx_d  = first_idx_q;
      second_idx_d = second_idx_q;
      first_val_d  = first_val_q;

      next_player = (player_q == LAST_PLAYER) ? '0 : player_q + 1'b1;
      running     = (state_q == S_PICK1) || (state_q == S_PICK2);
      wrap        = running && (presc_q == PRESC_LAST);
      timeout     = wrap && (secs_q == 5'd1);
      pick_ok     = sel_valid && ({1'b0, sel_idx} < CARD_LIMIT) && !matched_q[sel_idx] &&
                    ((state_q == S_PICK1) || ((state_q == S_PICK2) && (sel_idx != first_idx_q)));

      // A wrap at secs_left==1 never decrements; the timeout branch reloads unless a pick wins.
      if (running) begin
         presc_d = wrap ? '0 : presc_q + 1'b1;
         if (wrap && !timeout) secs_d = secs_q - 5'd1;
      end

      case (state_q)
         S_IDLE, S_OVER: begin
            if (start) begin
               state_d     = S_PICK1;
               player_d    = '0;
               face_d      = '0;
               matched_d   = '0;
               scores_d    = '0;
               presc_d     = '0;
               secs_d      = TURN_RELOAD;
               game_over_d = 1'b0;
               winner_d    = '0;
            end
         end
         S_PICK1: begin
            if (pick_ok) begin
               face_d[sel_idx] = 1'b1;
               first_idx_d     = sel_idx;
               first_val_d     = card_val;
               state_d         = S_PICK2;
            end else if (timeout) begin
               player_d = next_player;
               presc_d  = '0;
               secs_d   = TURN_RELOAD;
            end
         end
         S_PICK2: begin
            if (pick_ok) begin
               face_d[sel_idx] = 1'b1;
               second_idx_d    = sel_idx;
               if (card_val == first_val_q) begin
                  matched_d[sel_idx]     = 1'b1;
                  matched_d[first_idx_q] = 1'b1;
                  for (int p = 0; p < NUM_PLAYERS; p++) begin
                     if ((PW'(p) == player_q) && (scores_q[p*SW +: SW] != SCORE_MAX))
                        scores_d[p*SW +: SW] = scores_q[p*SW +: SW] + 1'b1;
                  end
                  presc_d = '0;
                  secs_d  = TURN_RELOAD;
                  state_d = (&matched_d) ? S_OVER : S_PICK1;
               end else begin
                  show_d  = '0;
                  state_d = S_SHOW;
               end
            end else if (timeout) begin
               face_d[first_idx_q] = 1'b0;
               player_d            = next_player;
               presc_d             = '0;
               secs_d              = TURN_RELOAD;
               state_d             = S_PICK1;
            end
         end
         S_SHOW: begin
            if (show_q == SHOW_LAST) begin
               face_d[first_idx_q]  = 1'b0;
               face_d[second_idx_q] = 1'b0;
               player_d             = next_player;
               presc_d              = '0;
               secs_d               = TURN_RELOAD;
               state_d              = S_PICK1;
            end else begin
               show_d = show_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Winner is judged on the final scores so it appears on the same edge as OVER.
      best    = '0;
      tie     = 1'b0;
      win_idx = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (scores_d[p*SW +: SW] > best) begin
            best    = scores_d[p*SW +: SW];
            win_idx = WW'(p + 1);
            tie     = 1'b0;
         end else if (scores_d[p*SW +: SW] == best) begin
            tie = 1'b1;
         end
      end
      if ((state_d == S_OVER) && (state_q != S_OVER)) begin
         game_over_d = 1'b1;
         winner_d    = tie ? '0 : win_idx;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         player_q     <= '0;
         face_q       <= '0;
         matched_q    <= '0;
         scores_q     <= '0;
         secs_q       <= TURN_RELOAD;
         game_over_q  <= 1'b0;
         winner_q     <= '0;
         presc_q      <= '0;
         show_q       <= '0;
         first_idx_q  <= '0;
         second_idx_q <= '0;
         first_val_q  <= '0;
      end else begin
         state_q      <= state_d;
         player_q     <= player_d;
         face_q       <= face_d;
         matched_q    <= matched_d;
         scores_q     <= scores_d;
         secs_q       <= secs_d;
         game_over_q  <= game_over_d;
         winner_q     <= winner_d;
         presc_q      <= presc_d;
         show_q       <= show_d;
         first_idx_q  <= first_idx_d;
         second_idx_q <= second_idx_d;
         first_val_q  <= first_val_d;
      end
   end

   assign state      = state_q;
   assign cur_player = player_q;
   assign face_up    = face_q;
   assign matched    = matched_q;
   assign scores     = scores_q;
   assign secs_left  = secs_q;
   assign game_over  = game_over_q;
   assign winner     = winner_q;

endmodule

// File: tb/tb_memory_turn_engine.sv
// tb/tb_memory_turn_engine.sv - directed vector bench for memory_turn_engine (4 cards, 2 players)
module tb_memory_turn_engine;

   logic       clk;
   logic       rst;
   logic       start;
   logic       sel_valid;
   logic [1:0] sel_idx;
   logic [0:0] card_val;
   logic [2:0] state;
   logic [0:0] cur_player;
   logic [3:0] face_up;
   logic [3:0] matched;
   logic [3:0] scores;
   logic [4:0] secs_left;
   logic       game_over;
   logic [1:0] winner;

   int tests = 0;
   int fails = 0;

   // Deck: cards 0,1 have value 0; cards 2,3 have value 1.
   assign card_val = sel_idx[1];

   memory_turn_engine #(
      .NUM_CARDS    (4),
      .NUM_PLAYERS  (2),
      .TICKS_PER_SEC(4),
      .TURN_SEC     (3),
      .SHOW_SEC     (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sel_valid (sel_valid),
      .sel_idx   (sel_idx),
      .card_val  (card_val),
      .state     (state),
      .cur_player(cur_player),
      .face_up   (face_up),
      .matched   (matched),
      .scores    (scores),
      .secs_left (secs_left),
      .game_over (game_over),
      .winner    (winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         act;
      logic [1:0] idx;
      logic [2:0] st;
      logic [3:0] fu;
      logic [3:0] m;
      logic       cp;
      logic [4:0] secs;
      logic [3:0] sc;
      logic       go;
      logic [1:0] win;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [2:0] st, input logic [3:0] fu,
                             input logic [3:0] m, input logic cp, input logic [4:0] secs,
                             input logic [3:0] sc, input logic go, input logic [1:0] win);
      chk({tag, " state"},      32'(state),      32'(st));
      chk({tag, " face_up"},    32'(face_up),    32'(fu));
      chk({tag, " matched"},    32'(matched),    32'(m));
      chk({tag, " cur_player"}, 32'(cur_player), 32'(cp));
      chk({tag, " secs_left"},  32'(secs_left),  32'(secs));
      chk({tag, " scores"},     32'(scores),     32'(sc));
      chk({tag, " game_over"},  32'(game_over),  32'(go));
      chk({tag, " winner"},     32'(winner),     32'(win));
   endtask

   // act: 0 = idle, 1 = start pulse, 2 = pick strobe
   task automatic do_cycle(input int act, input logic [1:0] idx);
      start     = (act == 1);
      sel_valid = (act == 2);
      sel_idx   = idx;
      @(posedge clk);
      #1;
      start     = 1'b0;
      sel_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1, 2'd0, 3'd1, 4'b0000, 4'b0000, 1'b0, 5'd3, 4'b0000, 1'b0, 2'd0};
      tbl[1]  = '{2, 2'd0, 3'd2, 4'b0001, 4'b0000, 1'b0, 5'd3, 4'b0000, 1'b0, 2'd0};
      tbl[2]  = '{2, 2'd1, 3'd1, 4'b0011, 4'b0011, 1'b0, 5'd3, 4'b0001, 1'b0, 2'd0};
      tbl[3]  = '{2, 2'd2, 3'd2, 4'b0111, 4'b0011, 1'b0, 5'd3, 4'b0001, 1'b0, 2'd0};
      tbl[4]  = '{2, 2'd0, 3'd2, 4'b0111, 4'b0011, 1'b0, 5'd3, 4'b0001, 1'b0, 2'd0};
      tbl[5]  = '{2, 2'd2, 3'd2, 4'b0111, 4'b0011, 1'b0, 5'd3, 4'b0001, 1'b0, 2'd0};
      tbl[6]  = '{1, 2'd0, 3'd2, 4'b0111, 4'b0011, 1'b0, 5'd2, 4'b0001, 1'b0, 2'd0};
      tbl[7]  = '{2, 2'd3, 3'd4, 4'b1111, 4'b1111, 1'b0, 5'd3, 4'b0010, 1'b1, 2'd1};
      tbl[8]  = '{1, 2'd0, 3'd1, 4'b0000, 4'b0000, 1'b0, 5'd3, 4'b0000, 1'b0, 2'd0};
      tbl[9]  = '{2, 2'd0, 3'd2, 4'b0001, 4'b0000, 1'b0, 5'd3, 4'b0000, 1'b0, 2'd0};
      tbl[10] = '{2, 2'd2, 3'd3, 4'b0101, 4'b0000, 1'b0, 5'd3, 4'b0000, 1'b0, 2'd0};
      tbl[11] = '{0, 2'd0, 3'd3, 4'b0101, 4'b0000, 1'b0, 5'd3, 4'b0000, 1'b0, 2'd0};
      tbl[12] = '{2, 2'd3, 3'd3, 4'b0101, 4'b0000, 1'b0, 5'd3, 4'b0000, 1'b0, 2'd0};
      tbl[13] = '{0, 2'd0, 3'd3, 4'b0101, 4'b0000, 1'b0, 5'd3, 4'b0000, 1'b0, 2'd0};
      tbl[14] = '{0, 2'd0, 3'd1, 4'b0000, 4'b0000, 1'b1, 5'd3, 4'b0000, 1'b0, 2'd0};
      tbl[15] = '{1, 2'd0, 3'd1, 4'b0000, 4'b0000, 1'b1, 5'd3, 4'b0000, 1'b0, 2'd0};
      tbl[16] = '{2, 2'd0, 3'd2, 4'b0001, 4'b0000, 1'b1, 5'd3, 4'b0000, 1'b0, 2'd0};
      tbl[17] = '{2, 2'd1, 3'd1, 4'b0011, 4'b0011, 1'b1, 5'd3, 4'b0100, 1'b0, 2'd0};

      rst       = 1'b0;
      start     = 1'b0;
      sel_valid = 1'b0;
      sel_idx   = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 3'd0, 4'b0000, 4'b0000, 1'b0, 5'd3, 4'b0000, 1'b0, 2'd0);
      rst = 1'b1;
      do_cycle(0, 2'd0);
      chk("idle hold state", 32'(state), 32'd0);

      for (int i = 0; i < 18; i++) begin
         do_cycle(tbl[i].act, tbl[i].idx);
         check_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].fu, tbl[i].m, tbl[i].cp,
                    tbl[i].secs, tbl[i].sc, tbl[i].go, tbl[i].win);
      end

      // Player 1 picks card 2 then lets the turn expire; first pick flips back down.
      do_cycle(2, 2'd2);
      chk("p1 pick2 state", 32'(state), 32'd2);
      chk("p1 pick2 face_up", 32'(face_up), 32'b0111);
      repeat (10) do_cycle(0, 2'd0);
      chk("pre-timeout state", 32'(state), 32'd2);
      chk("pre-timeout player", 32'(cur_player), 32'd1);
      chk("pre-timeout secs", 32'(secs_left), 32'd1);
      do_cycle(0, 2'd0);
      check_outs("pick2 timeout", 3'd1, 4'b0011, 4'b0011, 1'b0, 5'd3, 4'b0100, 1'b0, 2'd0);

      // Player 0 matches the last pair: 1-1 tie.
      do_cycle(2, 2'd2);
      do_cycle(2, 2'd3);
      check_outs("tie over", 3'd4, 4'b1111, 4'b1111, 1'b0, 5'd3, 4'b0101, 1'b1, 2'd0);

      // Restart from OVER, then an untouched turn runs out.
      do_cycle(1, 2'd0);
      check_outs("restart", 3'd1, 4'b0000, 4'b0000, 1'b0, 5'd3, 4'b0000, 1'b0, 2'd0);
      repeat (3) do_cycle(0, 2'd0);
      chk("t3 secs", 32'(secs_left), 32'd3);
      do_cycle(0, 2'd0);
      chk("t4 secs", 32'(secs_left), 32'd2);
      repeat (4) do_cycle(0, 2'd0);
      chk("t8 secs", 32'(secs_left), 32'd1);
      repeat (3) do_cycle(0, 2'd0);
      chk("t11 secs", 32'(secs_left), 32'd1);
      chk("t11 player", 32'(cur_player), 32'd0);
      do_cycle(0, 2'd0);
      chk("t12 player", 32'(cur_player), 32'd1);
      chk("t12 secs", 32'(secs_left), 32'd3);
      chk("t12 state", 32'(state), 32'd1);

      // A pick on the timeout cycle wins over the timeout.
      repeat (11) do_cycle(0, 2'd0);
      chk("pre-edge secs", 32'(secs_left), 32'd1);
      do_cycle(2, 2'd0);
      chk("edge pick state", 32'(state), 32'd2);
      chk("edge pick face_up", 32'(face_up), 32'b0001);
      chk("edge pick player", 32'(cur_player), 32'd1);

      // Asynchronous reset in the middle of PICK2.
      rst = 1'b0;
      #2;
      check_outs("async reset", 3'd0, 4'b0000, 4'b0000, 1'b0, 5'd3, 4'b0000, 1'b0, 2'd0);
      @(posedge clk);
      #1;
      check_outs("reset held", 3'd0, 4'b0000, 4'b0000, 1'b0, 5'd3, 4'b0000, 1'b0, 2'd0);
      rst = 1'b1;
      do_cycle(2, 2'd0);
      chk("idle pick ignored", 32'(face_up), 32'b0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
